led_pwm_ctrl: RTL

Parametrised N-channel LED driver replacing the fixed inversion between the SoC LED outputs and the board pins. A simple register port from the SoC sets each channel's mode (off, on, PWM dim, blink) and duty. A shared prescaler and PWM counter generate the brightness timing. Output polarity is selectable per board build.

---
 rtl/led_pwm_ctrl_if.sv | 14 +
 rtl/led_pwm_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl_if.sv
// Register port between the SoC and the LED driver: one write port, one read port
// with registered read data.
interface led_pwm_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/led_pwm_ctrl.sv
// N-channel LED driver: per-channel OFF/ON/PWM/BLINK with a shared prescaler,
// PWM counter and blink counter. Duty is shadowed at each PWM wrap.
module led_pwm_lane #(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [PWM_BITS+1:0] wr_val,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                blink_ph,
  output logic [15:0]         rd_val,
  output logic                led
);
  typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_PWM = 2'd2, M_BLINK = 2'd3} mode_e;
  localparam logic UNLIT = (ACTIVE_LOW != 0);

  mode_e               mode_q, mode_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, shadow_q, shadow_d;
  logic                led_q, led_d, pwm_on, lit;

  always_comb begin
    mode_d   = mode_q;
    duty_d   = duty_q;
    lit      = 1'b0;
    if (wr_en) begin
      duty_d = wr_val[PWM_BITS-1:0];
      mode_d = mode_e'(wr_val[PWM_BITS+1:PWM_BITS]);
    end
    // A write landing on the wrap edge is picked up at the following wrap.
    shadow_d = wrap ? duty_q : shadow_q;
    pwm_on   = pwm_cnt < shadow_q;
    case (mode_q)
      M_OFF:   lit = 1'b0;
      M_ON:    lit = 1'b1;
      M_PWM:   lit = pwm_on;
      default: lit = pwm_on & blink_ph;
    endcase
    led_d = lit ^ UNLIT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q   <= M_OFF;
      duty_q   <= '0;
      shadow_q <= '0;
      led_q    <= UNLIT;
    end else begin
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign rd_val = 16'({mode_q, duty_q});
  assign led    = led_q;
endmodule

module led_pwm_ctrl #(
  parameter int          NUM_LEDS     = 3,
  parameter int          PWM_BITS     = 8,
  parameter int          BLINK_BITS   = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd0,
  parameter int          ACTIVE_LOW   = 1,
  parameter int          ADDR_W       = 4
) (
  input  logic                clk,
  input  logic                resetn,
  led_pwm_ctrl_if.slave       bus,
  output logic                period_o,
  output logic [NUM_LEDS-1:0] led_o
);
  logic [15:0]                psc_q, psc_d, psc_cnt_q, psc_cnt_d, rd_q, rd_d;
  logic [PWM_BITS-1:0]        pwm_q, pwm_d;
  logic [BLINK_BITS-1:0]      blink_q, blink_d;
  logic                       period_q, period_d, tick, wrap;
  logic [NUM_LEDS-1:0][15:0]  lane_rd;

  always_comb begin
    tick  = (psc_cnt_q == '0);
    wrap  = tick && (pwm_q == '1);
    psc_d = psc_q;
    if (bus.wr_en && bus.wr_addr == ADDR_W'(NUM_LEDS)) psc_d = bus.wr_data;
    // Reload from the register only when the count expires, so a new
    // prescale never truncates or stretches the interval in progress.
    psc_cnt_d = tick ? psc_q : psc_cnt_q - 16'd1;
    pwm_d     = tick ? pwm_q + PWM_BITS'(1) : pwm_q;
    blink_d   = wrap ? blink_q + BLINK_BITS'(1) : blink_q;
    period_d  = wrap;
    rd_d      = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      if (bus.rd_addr == ADDR_W'(i)) rd_d = lane_rd[i];
    if (bus.rd_addr == ADDR_W'(NUM_LEDS)) rd_d = psc_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psc_q     <= PRESCALE_RST;
      psc_cnt_q <= '0;
      pwm_q     <= '0;
      blink_q   <= '0;
      period_q  <= 1'b0;
      rd_q      <= '0;
    end else begin
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
      pwm_q     <= pwm_d;
      blink_q   <= blink_d;
      period_q  <= period_d;
      rd_q      <= rd_d;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_lane
    led_pwm_lane #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .wr_en    (bus.wr_en && bus.wr_addr == ADDR_W'(g)),
      .wr_val   (bus.wr_data[PWM_BITS+1:0]),
      .wrap     (wrap),
      .pwm_cnt  (pwm_q),
      .blink_ph (blink_q[BLINK_BITS-1]),
      .rd_val   (lane_rd[g]),
      .led      (led_o[g])
    );
  end

  assign bus.rd_data = rd_q;
  assign period_o    = period_q;
endmodule
